// File: rtl/sample_image_data_storage_block_pkg.sv
// Shared types and constants for the 3-row sample-image window loader.
// Holds the FSM encoding, SRAM command codes and bus widths.
package sample_image_data_storage_block_pkg;

    localparam int PIX_IDX_W = 20;
    localparam int WINDOW_W  = 96;
    localparam int WORD_W    = 32;

    localparam logic [1:0] SI_MODE_IDLE = 2'b00;
    localparam logic [1:0] SI_MODE_READ = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        READ0,
        READ1,
        READ2,
        FILLED
    } state_t;

endpackage

// File: rtl/sample_image_data_storage_block.sv
// Loads a 3-row x 4-pixel window from SRAM: one read per row, each row one image_width further on.
// Minimum latency fill_buff -> buff_filled is 4 cycles; a READ state waits indefinitely for SI_dfb.
module sample_image_data_storage_block
    import sample_image_data_storage_block_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [31:0]          image_width,
    input  logic                 fill_buff,
    input  logic [PIX_IDX_W-1:0] ED_rpixNum,
    input  logic                 SI_dfb,
    input  logic [WORD_W-1:0]    SI_rdata,
    output logic [1:0]           SI_mode,
    output logic [PIX_IDX_W-1:0] SI_rpixNum,
    output logic [WINDOW_W-1:0]  ED_rdata,
    output logic                 buff_filled
);

    state_t               state_q;
    state_t               state_d;
    logic [PIX_IDX_W-1:0] base_q;
    logic [PIX_IDX_W-1:0] offset_q;
    logic [PIX_IDX_W-1:0] row_step;
    logic [WINDOW_W-1:0]  window_q;

    logic                 accept;
    logic                 capture;
    logic [1:0]           capture_word;

    assign row_step = image_width[PIX_IDX_W-1:0];

    // Next-state and capture decode; SI_dfb only steers registered updates.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture      = 1'b0;
        capture_word = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (fill_buff) begin
                    accept  = 1'b1;
                    state_d = READ0;
                end
            end
            READ0: begin
                if (SI_dfb) begin
                    capture      = 1'b1;
                    capture_word = 2'd0;
                    state_d      = READ1;
                end
            end
            READ1: begin
                if (SI_dfb) begin
                    capture      = 1'b1;
                    capture_word = 2'd1;
                    state_d      = READ2;
                end
            end
            READ2: begin
                if (SI_dfb) begin
                    capture      = 1'b1;
                    capture_word = 2'd2;
                    state_d      = FILLED;
                end
            end
            FILLED: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            offset_q <= '0;
            window_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                base_q   <= ED_rpixNum;
                offset_q <= '0;
            end
            // Row offset advances one image row per completed read.
            if (capture) begin
                offset_q <= offset_q + row_step;
                unique case (capture_word)
                    2'd0:    window_q[31:0]  <= SI_rdata;
                    2'd1:    window_q[63:32] <= SI_rdata;
                    2'd2:    window_q[95:64] <= SI_rdata;
                    default: window_q[31:0]  <= SI_rdata;
                endcase
            end
        end
    end

    always_comb begin
        SI_mode     = SI_MODE_IDLE;
        SI_rpixNum  = '0;
        buff_filled = 1'b0;
        unique case (state_q)
            READ0, READ1, READ2: begin
                SI_mode    = SI_MODE_READ;
                SI_rpixNum = base_q + offset_q;
            end
            FILLED: begin
                buff_filled = 1'b1;
            end
            default: begin
                SI_mode = SI_MODE_IDLE;
            end
        endcase
    end

    assign ED_rdata = window_q;

endmodule

// File: tb/tb_sample_image_data_storage_block.sv
// Directed and randomized checks of the window loader against a row-arithmetic reference model.
module tb_sample_image_data_storage_block;
    import sample_image_data_storage_block_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] image_width;
    logic        fill_buff;
    logic [19:0] ED_rpixNum;
    logic        SI_dfb;
    logic [31:0] SI_rdata;
    logic [1:0]  SI_mode;
    logic [19:0] SI_rpixNum;
    logic [95:0] ED_rdata;
    logic        buff_filled;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1..3 reading row phase-1, 4 filled.
    int          m_phase = 0;
    logic [19:0] m_base  = '0;
    logic [31:0] m_win [3];

    sample_image_data_storage_block dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .image_width (image_width),
        .fill_buff   (fill_buff),
        .ED_rpixNum  (ED_rpixNum),
        .SI_dfb      (SI_dfb),
        .SI_rdata    (SI_rdata),
        .SI_mode     (SI_mode),
        .SI_rpixNum  (SI_rpixNum),
        .ED_rdata    (ED_rdata),
        .buff_filled (buff_filled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        r, f, d;
        logic [19:0] p, k, exp_addr;
        logic [31:0] rd;
        r = n_rst; f = fill_buff; d = SI_dfb; p = ED_rpixNum; rd = SI_rdata;
        @(posedge clk);
        if (r) begin
            m_phase = 0;
            m_base  = '0;
            for (int i = 0; i < 3; i++) m_win[i] = '0;
        end else if (m_phase == 0) begin
            if (f) begin
                m_base  = p;
                m_phase = 1;
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else if (d) begin
            m_win[m_phase-1] = rd;
            m_phase++;
        end
        #1;
        k        = 20'(m_phase - 1);
        exp_addr = (m_phase >= 1 && m_phase <= 3) ? m_base + image_width[19:0] * k : 20'd0;
        chk("si_mode", 96'(SI_mode), (m_phase >= 1 && m_phase <= 3) ? 96'd1 : 96'd0);
        chk("si_rpixnum", 96'(SI_rpixNum), 96'(exp_addr));
        chk("buff_filled", 96'(buff_filled), (m_phase == 4) ? 96'd1 : 96'd0);
        chk("ed_rdata", ED_rdata, {m_win[2], m_win[1], m_win[0]});
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_win[i] = '0;
        n_rst = 1'b1; image_width = 32'd8; fill_buff = 1'b0;
        ED_rpixNum = '0; SI_dfb = 1'b0; SI_rdata = '0;
        step();
        step();
        chk("reset_rdata", ED_rdata, 96'd0);
        chk("reset_mode", 96'(SI_mode), 96'd0);
        n_rst = 1'b0;
        step();

        // Basic fill, width 8, base 0
        fill_buff = 1'b1; ED_rpixNum = 20'd0;
        step();
        chk("r19_addr0", 96'(SI_rpixNum), 96'd0);
        chk("r19_mode0", 96'(SI_mode), 96'd1);
        fill_buff = 1'b0; SI_dfb = 1'b1; SI_rdata = 32'h03020100;
        step();
        chk("r19_addr1", 96'(SI_rpixNum), 96'd8);
        SI_rdata = 32'h0B0A0908;
        step();
        chk("r19_addr2", 96'(SI_rpixNum), 96'd16);
        SI_rdata = 32'h13121110;
        step();
        chk("r19_filled_cycle4", 96'(buff_filled), 96'd1);
        chk("r19_window", ED_rdata, 96'h13121110_0B0A0908_03020100);
        SI_dfb = 1'b0;
        step();
        chk("r19_pulse_single", 96'(buff_filled), 96'd0);

        // Width 100, base 10
        image_width = 32'd100; fill_buff = 1'b1; ED_rpixNum = 20'd10;
        step();
        chk("r20_addr0", 96'(SI_rpixNum), 96'd10);
        fill_buff = 1'b0; SI_dfb = 1'b1; SI_rdata = 32'hAAAA0001;
        step();
        chk("r20_addr1", 96'(SI_rpixNum), 96'd110);
        SI_rdata = 32'hAAAA0002;
        step();
        chk("r20_addr2", 96'(SI_rpixNum), 96'd210);
        SI_rdata = 32'hAAAA0003;
        step();
        SI_dfb = 1'b0;
        step();

        // Stall in READ1, stray fill request mid-fill
        image_width = 32'd8; fill_buff = 1'b1; ED_rpixNum = 20'd0;
        step();
        fill_buff = 1'b0; SI_dfb = 1'b1; SI_rdata = 32'h11111111;
        step();
        SI_dfb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fill_buff = (i == 2); ED_rpixNum = 20'd50;
            step();
            chk("r21_stall_addr", 96'(SI_rpixNum), 96'd8);
            chk("r21_stall_nofill", 96'(buff_filled), 96'd0);
        end
        fill_buff = 1'b1; SI_dfb = 1'b1; SI_rdata = 32'h22222222;
        step();
        chk("r22_addr2_kept", 96'(SI_rpixNum), 96'd16);
        fill_buff = 1'b0; SI_rdata = 32'h33333333;
        step();
        chk("r21_filled", 96'(buff_filled), 96'd1);
        SI_dfb = 1'b0;
        step();

        // Reset during READ2
        fill_buff = 1'b1; ED_rpixNum = 20'd3;
        step();
        fill_buff = 1'b0; SI_dfb = 1'b1; SI_rdata = 32'h44444444;
        step();
        step();
        SI_dfb = 1'b0; n_rst = 1'b1;
        step();
        chk("r23_mode", 96'(SI_mode), 96'd0);
        chk("r23_rdata", ED_rdata, 96'd0);
        chk("r23_nofill", 96'(buff_filled), 96'd0);
        n_rst = 1'b0;
        step();

        // Back-to-back fills, fill_buff held high
        fill_buff = 1'b1; ED_rpixNum = 20'd20; SI_dfb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            SI_rdata = 32'hC0DE0000 | 32'(i);
            step();
        end
        fill_buff = 1'b0; SI_dfb = 1'b0;
        step();
        step();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (m_phase == 0 && (i % 40) == 0)
                image_width = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(1, 4096));
            n_rst      = ($urandom_range(0, 59) == 0);
            fill_buff  = ($urandom_range(0, 2) != 0);
            ED_rpixNum = 20'($urandom);
            SI_dfb     = ($urandom_range(0, 1) == 1);
            SI_rdata   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
